// File: rtl/arb_client.sv
// arb_client: requester-side burst agent for a 4-way round-robin arbiter.
// Optional grant-starvation abort is compiled in by defining ARB_CLIENT_TIMEOUT_EN.
module arb_client #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned LEN_W   = 4,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              req,
   input  logic              grant,
   output logic              bus_valid,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_last,
   output logic              busy,
   output logic              err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_param_check
      $error("arb_client: DEPTH must be a power of two >= 2 and TIMEOUT nonzero");
   end

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] mem_addr [DEPTH];
   logic [LEN_W-1:0]  mem_len  [DEPTH];
   logic [PTR_W:0]    wr_ptr;
   logic [PTR_W:0]    rd_ptr;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W-1:0]  cur_len;
   logic [LEN_W-1:0]  beat;
   logic              last_c;
   logic              abort_c;

   // Command FIFO: extra pointer bit distinguishes full from empty
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign busy      = (state != IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wr_ptr[PTR_W-1:0]] <= cmd_addr;
         mem_len[wr_ptr[PTR_W-1:0]]  <= cmd_len;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
      end
   end

`ifdef ARB_CLIENT_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] to_cnt;

   // Consecutive no-grant cycles spent in ACTIVE
   assign abort_c = (state == ACTIVE) && !grant && (to_cnt == TO_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || state != ACTIVE || grant) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + TO_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) err <= 1'b0;
      else     err <= abort_c;
   end
`else
   assign abort_c = 1'b0;
   assign err     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!empty) state_nxt = ACTIVE;
         ACTIVE:  if ((grant && last_c) || abort_c) state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic; RELEASE never issues a beat even if a stale grant is seen
   always_comb begin
      bus_valid = 1'b0;
      bus_addr  = '0;
      bus_last  = 1'b0;
      last_c    = (beat == cur_len);
      pop       = (state == IDLE) && !empty;
      if (state == ACTIVE && grant) begin
         bus_valid = 1'b1;
         bus_addr  = cur_addr + ADDR_W'(beat);
         bus_last  = last_c;
      end
   end

   // Burst registers and the request bit seen by the arbiter
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_addr <= '0;
         cur_len  <= '0;
         beat     <= '0;
         req      <= 1'b0;
      end else begin
         req <= (state_nxt == ACTIVE);
         if (pop) begin
            cur_addr <= mem_addr[rd_ptr[PTR_W-1:0]];
            cur_len  <= mem_len[rd_ptr[PTR_W-1:0]];
            beat     <= '0;
         end else if (bus_valid) begin
            beat <= beat + LEN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_arb_client.sv
// tb_arb_client: randomized scoreboard bench for arb_client (default build).
// Expected beats are expanded from accepted commands and checked in order by a monitor.
module tb_arb_client;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LEN_W  = 4;
   localparam int unsigned DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic              req;
   logic              grant = 1'b0;
   logic              bus_valid;
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_last;
   logic              busy;
   logic              err;

   arb_client #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .req(req), .grant(grant),
      .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_last(bus_last),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic              last;
   } beat_t;

   int    checks = 0;
   int    failures = 0;
   beat_t exp_q[$];
   beat_t b;
   int    occ = 0;
   int    low_run = 0;
   logic  prev_req = 1'b0;
   logic  had_burst = 1'b0;
   logic  rel = 1'b0;
   logic  req_seen = 1'b0;
   int    gmode = 0;   // 0 off, 1 on, 2 follows req one cycle later, 3 random, 4 manual

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Arbiter stand-in: grant changes just after the rising edge
   always @(posedge clk) begin
      #2;
      case (gmode)
         0: grant = 1'b0;
         1: grant = 1'b1;
         2: grant = req_seen;
         3: grant = ($urandom_range(0, 3) != 0);
         default: ;
      endcase
   end

   // Monitor and reference model, sampled mid-cycle
   always @(negedge clk) begin
      req_seen = req;
      if (rst) begin
         exp_q.delete();
         occ = 0; low_run = 0; prev_req = 1'b0; had_burst = 1'b0; rel = 1'b0;
      end else begin
         if (req && !prev_req) begin
            occ--;
            if (had_burst) chk("req_gap", 64'(low_run >= 2), 64'd1);
            had_burst = 1'b1;
            low_run = 0;
         end
         if (!req) low_run++;
         chk("cmd_ready", cmd_ready, 64'(occ < int'(DEPTH)));
         chk("busy", busy, 64'((occ > 0) || req || rel));
         chk("bus_valid", bus_valid, 64'(req & grant));
         chk("err", err, 64'd0);
         if (bus_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", bus_addr, 64'hdead_beef_dead_beef);
            end else begin
               b = exp_q.pop_front();
               chk("bus_addr", bus_addr, 64'(b.addr));
               chk("bus_last", bus_last, 64'(b.last));
            end
         end
         rel = bus_valid & bus_last;
         if (cmd_valid && cmd_ready) begin
            occ++;
            for (int i = 0; i <= int'(cmd_len); i++)
               exp_q.push_back(beat_t'{cmd_addr + ADDR_W'(i), (i == int'(cmd_len))});
         end
         prev_req = req;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n = 0;
      @(negedge clk);
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk(name, busy, 64'd0);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      @(negedge clk);
      while (!bus_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(name, bus_valid, 64'd1);
   endtask

   task automatic push(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
      step();
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = l;
   endtask

   initial begin
      int         n;
      int         run;
      int         acc;
      logic [5:0] pat;

      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 64'd1);
      chk("rst_req", req, 64'd0);
      chk("rst_bus_valid", bus_valid, 64'd0);
      chk("rst_bus_addr", bus_addr, 64'd0);
      chk("rst_bus_last", bus_last, 64'd0);
      chk("rst_busy", busy, 64'd0);
      chk("rst_err", err, 64'd0);

      // Single beat with registered-arbiter grant
      gmode = 2;
      push(32'h100, 4'd0);
      step();
      cmd_valid = 1'b0;
      @(negedge clk); chk("t1_req_before", req, 64'd0);
      @(negedge clk); chk("t1_req_rise", req, 64'd1);
      @(negedge clk); chk("t1_beat", bus_valid, 64'd1);
      chk("t1_addr", bus_addr, 64'h100);
      chk("t1_last", bus_last, 64'd1);
      @(negedge clk); chk("t1_req_drop", req, 64'd0);

      // Address wrap under continuous grant
      gmode = 1;
      wait_idle("t2_idle", 50);
      push(32'hFFFF_FFFE, 4'd3);
      step();
      cmd_valid = 1'b0;
      wait_valid("t2_first");
      chk("t2_addr0", bus_addr, 64'hFFFF_FFFE);
      run = 0;
      while (bus_valid && run < 20) begin
         run++;
         @(negedge clk);
      end
      chk("t2_run", 64'(run), 64'd4);

      // Grant lost mid-burst
      wait_idle("t3_idle", 50);
      gmode = 4;
      step();
      grant = 1'b0;
      push(32'h2000, 4'd3);
      step();
      cmd_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t3_req_up", req, 64'd1);
      pat = 6'b110011;
      for (int c = 0; c < 6; c++) begin
         step();
         grant = pat[c];
         @(negedge clk);
         chk("t3_req", req, 64'd1);
         chk("t3_valid", bus_valid, 64'(pat[c]));
      end
      step();
      grant = 1'b0;
      @(negedge clk);
      chk("t3_req_end", req, 64'd0);

      // FIFO fills while the first burst waits for grant
      gmode = 0;
      wait_idle("t4_idle", 50);
      acc = 0;
      push($urandom(), LEN_W'($urandom_range(0, 3)));
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (cmd_valid && cmd_ready) acc++;
         step();
         cmd_addr = $urandom();
         cmd_len  = LEN_W'($urandom_range(0, 3));
      end
      cmd_valid = 1'b0;
      chk("t4_accepts", 64'(acc), 64'd5);
      @(negedge clk);
      chk("t4_full", cmd_ready, 64'd0);
      gmode = 1;
      wait_idle("t4_drain", 200);
      chk("t4_empty", 64'(exp_q.size()), 64'd0);

      // Reset mid-burst with two entries queued
      push(32'h3000, 4'd3);
      push(32'h4000, 4'd1);
      push(32'h5000, 4'd1);
      step();
      cmd_valid = 1'b0;
      wait_valid("t5_beat");
      #1 rst = 1'b1;
      step();
      @(negedge clk);
      chk("t5_req", req, 64'd0);
      chk("t5_bus_valid", bus_valid, 64'd0);
      chk("t5_busy", busy, 64'd0);
      chk("t5_cmd_ready", cmd_ready, 64'd1);
      step();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("t5_no_beat", bus_valid, 64'd0);
      end

      // Randomized traffic with random grant
      gmode = 3;
      for (int c = 0; c < 400; c++) begin
         step();
         cmd_valid = ($urandom_range(0, 2) == 0);
         cmd_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom();
         cmd_len   = LEN_W'($urandom_range(0, 15));
      end
      step();
      cmd_valid = 1'b0;
      gmode = 1;
      wait_idle("drain_idle", 400);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
